// File: rtl/eth_cfg_loader.sv
// Configuration sequencer for the Ethernet bridge: serially writes MAC, IP and the UDP port
// table into the bridge config port, and keeps RX disabled while a load is in flight.
module eth_cfg_loader #(
  parameter int unsigned N_UDP       = 2,
  parameter int unsigned GAP         = 3,
  parameter int unsigned STARTUP_DLY = 16,
  parameter int unsigned AUTO_RELOAD = 1
) (
  input  logic               cfg_clk,
  input  logic               rst_n,
  input  logic [47:0]        mac,
  input  logic [31:0]        ip,
  input  logic [16*N_UDP-1:0] udp_ports,
  input  logic               start,
  input  logic               rx_enable_req,
  output logic               cfg_valid,
  output logic [4:0]         cfg_addr,
  output logic [7:0]         cfg_wdata,
  output logic               cfg_enable_rx,
  output logic               busy,
  output logic               load_done,
  output logic [7:0]         load_count
);

  localparam int unsigned NumWrites = 10 + 2 * N_UDP;
  localparam int unsigned SnapW     = 80 + 16 * N_UDP;
  localparam logic [4:0]  IdxLast   = 5'(NumWrites - 1);
  localparam logic [3:0]  GapLast   = 4'(GAP - 1);
  localparam logic [7:0]  WaitLast  = 8'(STARTUP_DLY - 1);

  typedef enum logic [1:0] {S_WAIT, S_WRITE, S_GAP, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [3:0]       gap_q, gap_d;
  logic [7:0]       wait_q, wait_d;
  logic             pend_q, pend_d;
  logic [SnapW-1:0] snap_q, snap_d;
  logic             finish;

  logic             valid_q, valid_d;
  logic [4:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       count_q, count_d;

  logic [SnapW-1:0] live;
  logic             changed;
  logic             reload_req;

  assign live       = {mac, ip, udp_ports};
  assign changed    = (AUTO_RELOAD != 0) && (live != snap_q);
  assign reload_req = start || changed;

  // Byte table indexed directly by write index; unused slots pad the 5-bit index space.
  logic [7:0] wr_byte [32];

  for (genvar k = 0; k < 10; k++) begin : g_macip
    assign wr_byte[k] = snap_d[SnapW-1-8*k -: 8];
  end

  // Port k high byte first: byte j of the UDP region lives at bit offset 8*(j^1).
  for (genvar k = 0; k < 2 * N_UDP; k++) begin : g_udp
    assign wr_byte[10+k] = snap_d[8*(k^1) +: 8];
  end

  for (genvar k = NumWrites; k < 32; k++) begin : g_pad
    assign wr_byte[k] = 8'h00;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    wait_d  = wait_q;
    pend_d  = pend_q;
    snap_d  = snap_q;
    finish  = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        // The snapshot taken on exit absorbs input changes, so only start is remembered here.
        if (start) pend_d = 1'b1;
        if (wait_q == WaitLast) begin
          state_d = S_WRITE;
          idx_d   = '0;
          snap_d  = live;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITE: begin
        if (reload_req) pend_d = 1'b1;
        if (idx_q == IdxLast) begin
          state_d = S_DONE;
          finish  = 1'b1;
        end else if (GAP == 0) begin
          idx_d = idx_q + 5'd1;
        end else begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (reload_req) pend_d = 1'b1;
        if (gap_q == GapLast) begin
          state_d = S_WRITE;
          idx_d   = idx_q + 5'd1;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_DONE: begin
        if (start || pend_q || changed) begin
          state_d = S_WRITE;
          idx_d   = '0;
          snap_d  = live;
          pend_d  = 1'b0;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Output next-state is derived from the FSM next-state so every output is a flop.
  always_comb begin
    valid_d = (state_d == S_WRITE);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (valid_d) begin
      addr_d  = (idx_d < 5'd10) ? idx_d : idx_d + 5'd6;
      wdata_d = wr_byte[idx_d];
    end
    busy_d  = (state_d != S_DONE);
    en_d    = (state_d == S_DONE) && rx_enable_req;
    done_d  = finish;
    count_d = count_q;
    if (finish && count_q != 8'hFF) count_d = count_q + 8'd1;
  end

  always_ff @(posedge cfg_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      idx_q   <= '0;
      gap_q   <= '0;
      wait_q  <= '0;
      pend_q  <= 1'b0;
      snap_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      snap_q  <= snap_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign cfg_valid     = valid_q;
  assign cfg_addr      = addr_q;
  assign cfg_wdata     = wdata_q;
  assign cfg_enable_rx = en_q;
  assign busy          = busy_q;
  assign load_done     = done_q;
  assign load_count    = count_q;

endmodule

// File: doc/eth_cfg_loader.md
Name: eth_cfg_loader

Overview:
- Configuration sequencer that sits upstream of the Ethernet GTX bridge's configuration port.
- After reset, it serially writes the station MAC, IP and the UDP port table into the bridge through cfg_valid/cfg_addr/cfg_wdata.
- It gates cfg_enable_rx so the receive path is never enabled while the configuration is half-written.
- It reloads automatically on an explicit start pulse, or when the MAC/IP/port inputs change.

Parameters:
- N_UDP, 2: number of UDP port entries written; legal range 1..8.
- GAP, 3: idle cycles between consecutive cfg_valid pulses; legal range 0..15.
- STARTUP_DLY, 16: cycles after reset release before the first automatic load; legal range 1..255.
- AUTO_RELOAD, 1: 1 = a change on ip/mac/udp_ports triggers a reload; 0 = only start triggers a reload.

Ports:
- cfg_clk  input  1  single clock for the block; same clock as the bridge's cfg_clk.
- rst_n  input  1  asynchronous, active-low reset.
- mac  input  48  station MAC, synchronous to cfg_clk.
- ip  input  32  station IPv4 address, synchronous to cfg_clk.
- udp_ports  input  16*N_UDP  port k is bits [16k+15:16k].
- start  input  1  single-cycle reload request.
- rx_enable_req  input  1  software request to enable RX once configured.
- cfg_valid  output  1  one-cycle write strobe.
- cfg_addr  output  5  bit 4: 0 = MAC/IP, 1 = UDP; bits [3:0] = byte address.
- cfg_wdata  output  8  write byte.
- cfg_enable_rx  output  1  receive enable to the bridge.
- busy  output  1  high while a load sequence is in progress.
- load_done  output  1  one-cycle pulse when a sequence completes.
- load_count  output  8  completed loads, saturates at 255.

Behaviour:
- Reset (async, rst_n low): all outputs are 0, the FSM is in S_WAIT, and the counters, snapshot and pending flag are cleared. A reset asserted mid-sequence aborts it immediately, with no further cfg_valid.
- All outputs are registered.
- Write list (W = 10 + 2*N_UDP entries), in this order:
  - i = 0..5: addr i, data mac[47-8i -: 8] (MSB first).
  - i = 6..9: addr i, data ip[31-8(i-6) -: 8].
  - UDP entry k: addr 16+2k carries port[15:8], then addr 17+2k carries port[7:0].
- Data is taken from a snapshot of {mac, ip, udp_ports} captured on the edge that enters S_WRITE. Input changes during a load never tear a sequence.
- FSM states:
  - S_WAIT: counts STARTUP_DLY cycles from reset release, then goes to S_WRITE (snapshot taken, index 0).
  - S_WRITE: one cycle with cfg_valid = 1, cfg_addr/cfg_wdata for the current index.
    - If this is the last index: go to S_DONE.
    - Else if GAP = 0: stay in S_WRITE with index+1.
    - Else: go to S_GAP.
  - S_GAP: GAP cycles with cfg_valid = 0, then S_WRITE with index+1. Consecutive strobes are therefore exactly GAP+1 cycles apart.
  - S_DONE: idle.
    - Trigger = start, or pending, or (AUTO_RELOAD and live inputs != snapshot).
    - A trigger goes to S_WRITE (new snapshot, index 0, pending cleared).
- cfg_addr/cfg_wdata hold their last value when cfg_valid = 0.
- busy = 1 in S_WAIT, S_WRITE and S_GAP; 0 in S_DONE.
- Pending flag: start, or an input change with AUTO_RELOAD = 1, arriving in S_WAIT/S_WRITE/S_GAP sets pending. The current sequence completes first; the reload begins on the first S_DONE cycle. Multiple requests collapse into one reload.
- Completion, on the cycle after the last strobe (first S_DONE cycle):
  - load_done pulses for exactly 1 cycle.
  - load_count increments, saturating at 255.
  - cfg_enable_rx = rx_enable_req.
- cfg_enable_rx:
  - Forced 0 whenever busy = 1, including during reloads; it falls on the cycle after the trigger.
  - In S_DONE it follows rx_enable_req with 1-cycle latency.
- A start pulse coinciding with completion sets pending, so the next sequence begins immediately.
- Inter-sequence turnaround: the first S_DONE cycle evaluates the trigger, so the next strobe appears 2 cycles after the previous last strobe.

Test Plan:
- Startup load (defaults). Stimulus: mac = 00:11:22:33:44:55, ip = C0A80102, udp_ports = {0BB8, 1F40}, rx_enable_req = 1.
  - 14 strobes, 4 cycles apart.
  - Addr sequence 0–9, then 16, 17, 18, 19.
  - Data sequence 00 11 22 33 44 55 C0 A8 01 02 1F 40 0B B8.
  - load_done pulses 1 cycle after the last strobe; cfg_enable_rx rises on that same cycle; load_count = 1.
- GAP = 0: strobes on 14 consecutive cycles; busy drops on the cycle after the last strobe.
- Input change: ip changes to C0A80103 in S_DONE.
  - cfg_enable_rx goes 0 the next cycle.
  - A full 14-write reload runs with byte 9 = 03.
  - load_count = 2.
  - With AUTO_RELOAD = 0, no writes occur.
- start during write 5 of a load: the sequence finishes uninterrupted, then exactly one reload follows 2 cycles after the last strobe; three starts give the same result.
- rst_n pulsed low during write 7: cfg_valid is 0 immediately and all outputs are 0; after release the full sequence restarts from addr 0 after STARTUP_DLY.
- load_count saturation: 260 start-triggered loads -> load_count holds at 255 while load_done still pulses on every completion.
